// File: rtl/sram_req_seq_8_32_if.sv
// Fabric-side write/read request and read-response handshake bundle for sram_req_seq_8_32.
// master = fabric requester, slave = the sequencer.
interface sram_req_seq_8_32_if;
  logic        wr_valid;
  logic        wr_ready;
  logic [9:0]  wr_addr;
  logic [31:0] wr_data;
  logic        rd_valid;
  logic        rd_ready;
  logic [9:0]  rd_addr;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;

  modport master (
    output wr_valid, wr_addr, wr_data, rd_valid, rd_addr, rsp_ready,
    input  wr_ready, rd_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  wr_valid, wr_addr, wr_data, rd_valid, rd_addr, rsp_ready,
    output wr_ready, rd_ready, rsp_valid, rsp_data
  );
endinterface

// File: rtl/sram_req_seq_8_32.sv
// Request sequencer for the 8/32 SRAM interface: issues writes/reads, tracks read latency and
// buffers returned data in a credit-limited FIFO. Optional read-stall counter: SRAM_REQ_SEQ_PERF_EN.

module sram_req_seq_8_32_chk #(
  parameter int RSP_DEPTH = 4
) (
  input logic clk,
  input logic rst_n,
  input logic push_s,
  input logic full_s
);
  // The credit rule must keep returning data from ever meeting a full FIFO
  always @(posedge clk) begin
    if (rst_n) begin
      assert (!(push_s && full_s))
        else $error("sram_req_seq_8_32: response FIFO overflow (depth %0d)", RSP_DEPTH);
    end
  end
endmodule

module sram_req_seq_8_32 #(
  parameter int RSP_DEPTH = 4,
  parameter int BASE_LAT  = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  sram_req_seq_8_32_if.slave  bus,
  input  logic [1:0]          cfg_conf,
  input  logic                cfg_out_reg,
  output logic                csb,
  output logic                web,
  output logic                reb,
  output logic [9:0]          addr_w,
  output logic [9:0]          addr_r,
  output logic [31:0]         d_fabric_in,
  output logic [1:0]          conf,
  output logic                out_reg,
  input  logic [31:0]         d_fabric_out,
  output logic                busy
`ifdef SRAM_REQ_SEQ_PERF_EN
  ,
  input  logic                perf_clr,
  output logic [15:0]         rd_stall_cnt
`endif
);
  localparam int PW = $clog2(RSP_DEPTH);
  localparam int CW = PW + 1;
  localparam int SW = ((CW > 3) ? CW : 3) + 1;

  logic          init_r;
  logic [3:0]    lat_sr_r;
  logic [2:0]    inflight_r;
  logic [PW-1:0] wr_ptr_r;
  logic [PW-1:0] rd_ptr_r;
  logic [CW-1:0] count_r;
  logic [31:0]   mem_r [RSP_DEPTH];

  logic          wr_ready_s;
  logic          rd_ready_s;
  logic          wr_fire_s;
  logic          rd_fire_s;
  logic          collide_s;
  logic          credit_ok_s;
  logic [SW-1:0] credit_sum_s;
  logic          ret_s;
  logic          push_s;
  logic          pop_s;
  logic          empty_s;
  logic          full_s;

  // Issue decode: the interface registers everything, so requests go out combinationally
  always_comb begin
    collide_s    = bus.wr_valid & (bus.rd_addr == bus.wr_addr);
    credit_sum_s = SW'(inflight_r) + SW'(count_r);
    credit_ok_s  = (credit_sum_s < SW'(RSP_DEPTH));
    wr_ready_s   = init_r & rst_n;
    rd_ready_s   = init_r & rst_n & credit_ok_s & ~collide_s;
    wr_fire_s    = bus.wr_valid & wr_ready_s;
    rd_fire_s    = bus.rd_valid & rd_ready_s;
    empty_s      = (count_r == {CW{1'b0}});
    full_s       = (count_r == CW'(RSP_DEPTH));
    pop_s        = ~empty_s & bus.rsp_ready;
    if (cfg_out_reg) begin
      ret_s = lat_sr_r[BASE_LAT];
    end else begin
      ret_s = lat_sr_r[BASE_LAT-1];
    end
    push_s = ret_s;
  end

  assign bus.wr_ready  = wr_ready_s;
  assign bus.rd_ready  = rd_ready_s;
  assign bus.rsp_valid = ~empty_s;
  assign bus.rsp_data  = mem_r[rd_ptr_r];

  assign web         = ~wr_fire_s;
  assign reb         = ~rd_fire_s;
  assign csb         = ~(wr_fire_s | rd_fire_s);
  assign addr_w      = bus.wr_addr;
  assign addr_r      = bus.rd_addr;
  assign d_fabric_in = bus.wr_data;
  assign conf        = cfg_conf;
  assign out_reg     = cfg_out_reg;
  assign busy        = (inflight_r != 3'd0) | ~empty_s;

  // Init flag, return-cycle shift register and in-flight read count
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      init_r     <= 1'b0;
      lat_sr_r   <= 4'b0000;
      inflight_r <= 3'd0;
    end else begin
      init_r   <= 1'b1;
      lat_sr_r <= {lat_sr_r[2:0], rd_fire_s};
      case ({rd_fire_s, ret_s})
        2'b10:   inflight_r <= inflight_r + 3'd1;
        2'b01:   inflight_r <= inflight_r - 3'd1;
        default: inflight_r <= inflight_r;
      endcase
    end
  end

  // Response FIFO pointers and occupancy; reads dropped by reset never reach here
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PW'(1'b1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PW'(1'b1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CW'(1'b1);
        2'b01:   count_r <= count_r - CW'(1'b1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Response storage, captured on the return cycle
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= d_fabric_out;
    end
  end

`ifdef SRAM_REQ_SEQ_PERF_EN
  logic [15:0] stall_cnt_r;

  // Saturating count of cycles a live read request is held off
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt_r <= 16'h0000;
    end else if (perf_clr) begin
      stall_cnt_r <= 16'h0000;
    end else if (bus.rd_valid & init_r & ~rd_ready_s & (stall_cnt_r != 16'hFFFF)) begin
      stall_cnt_r <= stall_cnt_r + 16'h0001;
    end else begin
      stall_cnt_r <= stall_cnt_r;
    end
  end

  assign rd_stall_cnt = stall_cnt_r;
`endif

  sram_req_seq_8_32_chk #(.RSP_DEPTH(RSP_DEPTH)) u_chk (
    .clk    (clk),
    .rst_n  (rst_n),
    .push_s (push_s),
    .full_s (full_s)
  );
endmodule

// File: tb/tb_sram_req_seq_8_32.sv
// Directed bench for sram_req_seq_8_32 with a behavioural SRAM-interface model and a
// response scoreboard; stimulus changes on negedge, checks one time unit later.
module tb_sram_req_seq_8_32;
  localparam logic [31:0] JUNK = 32'hBADC_0FFE;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  cfg_conf;
  logic        cfg_out_reg;
  logic        csb, web, reb;
  logic [9:0]  addr_w, addr_r;
  logic [31:0] d_fabric_in, d_fabric_out;
  logic [1:0]  conf;
  logic        out_reg, busy;
`ifdef SRAM_REQ_SEQ_PERF_EN
  logic        perf_clr;
  logic [15:0] rd_stall_cnt;
`endif

  int checks = 0;
  int errors = 0;
  logic [31:0] sb_q[$];

  always #5 clk = ~clk;

  sram_req_seq_8_32_if bus ();

  sram_req_seq_8_32 #(.RSP_DEPTH(4), .BASE_LAT(3)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .cfg_conf(cfg_conf), .cfg_out_reg(cfg_out_reg),
    .csb(csb), .web(web), .reb(reb), .addr_w(addr_w), .addr_r(addr_r),
    .d_fabric_in(d_fabric_in), .conf(conf), .out_reg(out_reg),
    .d_fabric_out(d_fabric_out), .busy(busy)
`ifdef SRAM_REQ_SEQ_PERF_EN
    , .perf_clr(perf_clr), .rd_stall_cnt(rd_stall_cnt)
`endif
  );

  function automatic logic [31:0] init_word(input logic [9:0] a);
    return {12'hC0D, a, ~a};
  endfunction

  // SRAM interface model: registered write, read data valid LAT cycles after issue
  logic [31:0] sram [1024];
  bit   [1023:0] sram_v;
  logic [31:0] pd [1:4];
  bit   [4:1]  pv;

  function automatic logic [31:0] sram_rd(input logic [9:0] a);
    return sram_v[a] ? sram[a] : init_word(a);
  endfunction

  always @(posedge clk) begin
    if (csb === 1'b0 && web === 1'b0) begin
      sram[addr_w]   <= d_fabric_in;
      sram_v[addr_w] <= 1'b1;
    end
    pv    <= {pv[3:1], (csb === 1'b0 && reb === 1'b0)};
    pd[1] <= sram_rd(addr_r);
    pd[2] <= pd[1];
    pd[3] <= pd[2];
    pd[4] <= pd[3];
  end

  always_comb begin
    if (cfg_out_reg) d_fabric_out = pv[4] ? pd[4] : JUNK;
    else             d_fabric_out = pv[3] ? pd[3] : JUNK;
  end

  // Reference contents as the bench intends them
  logic [31:0] ref_mem [1024];
  bit   [1023:0] ref_v;

  function automatic logic [31:0] exp_word(input logic [9:0] a);
    return ref_v[a] ? ref_mem[a] : init_word(a);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Response monitor: every consumed response must match the head of the scoreboard
  always @(negedge clk) begin
    #1;
    if (rst_n === 1'b1 && bus.rsp_valid === 1'b1 && bus.rsp_ready === 1'b1) begin
      if (sb_q.size() == 0) chk("rsp_unexpected", 32'(sb_q.size()), 32'd1);
      else                  chk("rsp_data", bus.rsp_data, sb_q.pop_front());
    end
  end

  task automatic do_write(input logic [9:0] a, input logic [31:0] d);
    int n = 0;
    bus.wr_valid = 1'b1; bus.wr_addr = a; bus.wr_data = d;
    #1;
    while (bus.wr_ready !== 1'b1 && n < 20) begin @(negedge clk); #1; n++; end
    chk("wr_accept", 32'(bus.wr_ready), 32'd1);
    chk("wr_web", 32'(web), 32'd0);
    chk("wr_addr_w", 32'(addr_w), 32'(a));
    ref_mem[a] = d; ref_v[a] = 1'b1;
    @(negedge clk);
    bus.wr_valid = 1'b0;
  endtask

  task automatic do_read(input logic [9:0] a, input bit expect_rsp);
    int n = 0;
    bus.rd_valid = 1'b1; bus.rd_addr = a;
    #1;
    while (bus.rd_ready !== 1'b1 && n < 20) begin @(negedge clk); #1; n++; end
    chk("rd_accept", 32'(bus.rd_ready), 32'd1);
    chk("rd_reb", 32'(reb), 32'd0);
    chk("rd_addr_r", 32'(addr_r), 32'(a));
    if (expect_rsp) sb_q.push_back(exp_word(a));
    @(negedge clk);
    bus.rd_valid = 1'b0;
  endtask

  // Entered on the cycle after a read issue with rsp_ready low
  task automatic measure_lat(input string tag, input int exp_k);
    int k = 1;
    #1;
    chk({tag, "_inflight1"}, 32'(dut.inflight_r), 32'd1);
    chk({tag, "_busy"}, 32'(busy), 32'd1);
    while (bus.rsp_valid !== 1'b1 && k < 12) begin @(negedge clk); #1; k++; end
    chk({tag, "_cycles"}, 32'(k), 32'(exp_k));
    chk({tag, "_inflight0"}, 32'(dut.inflight_r), 32'd0);
    @(negedge clk);
    bus.rsp_ready = 1'b1;
  endtask

  task automatic wait_drain(input string tag);
    int n = 0;
    while ((sb_q.size() != 0 || busy !== 1'b0) && n < 60) begin @(negedge clk); #1; n++; end
    chk({tag, "_drained"}, 32'(sb_q.size()), 32'd0);
    chk({tag, "_idle"}, 32'(busy), 32'd0);
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "bench did not finish");
  end

  initial begin
    int acc;
    int n;
    rst_n = 1'b0; cfg_conf = 2'b10; cfg_out_reg = 1'b0;
    bus.wr_valid = 1'b1; bus.wr_addr = 10'h055; bus.wr_data = 32'h1111_2222;
    bus.rd_valid = 1'b1; bus.rd_addr = 10'h066; bus.rsp_ready = 1'b0;
`ifdef SRAM_REQ_SEQ_PERF_EN
    perf_clr = 1'b0;
`endif

    // Reset hold with both requests asserted
    repeat (3) begin
      @(negedge clk); #1;
      chk("rst_csb", 32'(csb), 32'd1);
      chk("rst_web", 32'(web), 32'd1);
      chk("rst_reb", 32'(reb), 32'd1);
      chk("rst_wr_ready", 32'(bus.wr_ready), 32'd0);
      chk("rst_rd_ready", 32'(bus.rd_ready), 32'd0);
      chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1; bus.wr_valid = 1'b0; bus.rd_valid = 1'b0;
    #1;
    chk("init_wr_ready_c1", 32'(bus.wr_ready), 32'd0);
    @(negedge clk); #1;
    chk("init_wr_ready_c2", 32'(bus.wr_ready), 32'd1);
    chk("init_rd_ready_c2", 32'(bus.rd_ready), 32'd1);
    chk("conf_pass", 32'(conf), 32'd2);
    chk("out_reg0", 32'(out_reg), 32'd0);
    @(negedge clk);

    // Write then read, out_reg = 0
    do_write(10'h3A5, 32'hDEADBEEF);
    do_read(10'h3A5, 1'b1);
    measure_lat("lat3", 4);
    wait_drain("lat3");

    // Same sequence with the output register enabled
    cfg_out_reg = 1'b1;
    @(negedge clk); #1;
    chk("out_reg1", 32'(out_reg), 32'd1);
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    do_write(10'h3A5, 32'h1357_2468);
    do_read(10'h3A5, 1'b1);
    measure_lat("lat4", 5);
    wait_drain("lat4");
    cfg_out_reg = 1'b0;
    @(negedge clk);

    // Write/read collision on the same address: write wins, read follows
    bus.wr_valid = 1'b1; bus.wr_addr = 10'h012; bus.wr_data = 32'h0BAD_F00D;
    bus.rd_valid = 1'b1; bus.rd_addr = 10'h012;
    #1;
    chk("col_web", 32'(web), 32'd0);
    chk("col_reb", 32'(reb), 32'd1);
    chk("col_rd_ready", 32'(bus.rd_ready), 32'd0);
    ref_mem[10'h012] = 32'h0BAD_F00D; ref_v[10'h012] = 1'b1;
    @(negedge clk);
    bus.wr_valid = 1'b0;
    #1;
    chk("col_rd_ready_next", 32'(bus.rd_ready), 32'd1);
    chk("col_reb_next", 32'(reb), 32'd0);
    sb_q.push_back(exp_word(10'h012));
    @(negedge clk);
    bus.rd_valid = 1'b0;
    wait_drain("col");

    // Simultaneous write and read to different addresses
    bus.wr_valid = 1'b1; bus.wr_addr = 10'h100; bus.wr_data = 32'hCAFE_F00D;
    bus.rd_valid = 1'b1; bus.rd_addr = 10'h3A5;
    #1;
    chk("dual_web", 32'(web), 32'd0);
    chk("dual_reb", 32'(reb), 32'd0);
    chk("dual_csb", 32'(csb), 32'd0);
    sb_q.push_back(exp_word(10'h3A5));
    ref_mem[10'h100] = 32'hCAFE_F00D; ref_v[10'h100] = 1'b1;
    @(negedge clk);
    bus.wr_valid = 1'b0; bus.rd_valid = 1'b0;
    do_read(10'h100, 1'b1);
    wait_drain("dual");

    // Credit limit with response backpressure
    bus.rsp_ready = 1'b0;
    acc = 0;
    for (int c = 0; c < 12; c++) begin
      bus.rd_valid = 1'b1; bus.rd_addr = 10'h200 + 10'(acc);
      #1;
      if (bus.rd_ready === 1'b1) begin sb_q.push_back(exp_word(bus.rd_addr)); acc++; end
      @(negedge clk);
    end
    bus.rd_addr = 10'h200 + 10'(acc);
    #1;
    chk("credit_accepted", 32'(acc), 32'd4);
    chk("credit_rd_ready", 32'(bus.rd_ready), 32'd0);
    chk("credit_rsp_valid", 32'(bus.rsp_valid), 32'd1);
    @(negedge clk);
    bus.rsp_ready = 1'b1;
    n = 0;
    while (acc < 6 && n < 40) begin
      bus.rd_valid = 1'b1; bus.rd_addr = 10'h200 + 10'(acc);
      #1;
      if (bus.rd_ready === 1'b1) begin sb_q.push_back(exp_word(bus.rd_addr)); acc++; end
      @(negedge clk);
      n++;
    end
    bus.rd_valid = 1'b0;
    chk("credit_total", 32'(acc), 32'd6);
    wait_drain("credit");

    // Reset with two reads in flight: their data must be dropped
    bus.rd_valid = 1'b1; bus.rd_addr = 10'h300;
    #1;
    chk("mid_rd0", 32'(bus.rd_ready), 32'd1);
    @(negedge clk);
    bus.rd_addr = 10'h301;
    #1;
    chk("mid_rd1", 32'(bus.rd_ready), 32'd1);
    @(negedge clk);
    bus.rd_valid = 1'b0; rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("mid_busy", 32'(busy), 32'd0);
    chk("mid_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    repeat (8) begin
      @(negedge clk); #1;
      chk("mid_no_rsp", 32'(bus.rsp_valid), 32'd0);
    end
    chk("mid_sb_empty", 32'(sb_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/sram_req_seq_8_32.md
Name: sram_req_seq_8_32

Overview:
- Fabric-side request sequencer that sits directly upstream of the 8/32 SRAM interface block and also takes that block's read data back.
- Accepts independent write and read request streams with valid/ready handshakes.
- Drives the interface's active-low csb/web/reb, addresses, data and config.
- Tracks in-flight reads across the interface's fixed pipeline latency and buffers returned data in a response FIFO with backpressure.

Parameters:
- RSP_DEPTH, 4, response FIFO entries; also the credit limit on reads in flight plus reads buffered (power of 2, ≥4).
- BASE_LAT, 3, read latency of the interface in cycles with out_reg=0, measured from the issue cycle to the cycle d_fabric_out is valid.

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset.
- wr_valid  in  1  write request valid.
- wr_ready  out  1  write request accepted.
- wr_addr  in  10  write address, {subaddr[1:0], baseaddr[7:0]}.
- wr_data  in  32  write data.
- rd_valid  in  1  read request valid.
- rd_ready  out  1  read request accepted.
- rd_addr  in  10  read address.
- rsp_valid  out  1  read response valid.
- rsp_ready  in  1  read response consumed.
- rsp_data  out  32  read response data.
- cfg_conf  in  2  width config; static, change only when idle.
- cfg_out_reg  in  1  output-register select; static, change only when idle.
- csb  out  1  to interface; active-low chip select.
- web  out  1  to interface; active-low write.
- reb  out  1  to interface; active-low read.
- addr_w  out  10  to interface.
- addr_r  out  10  to interface.
- d_fabric_in  out  32  to interface.
- conf  out  2  to interface, equal to cfg_conf.
- out_reg  out  1  to interface, equal to cfg_out_reg.
- d_fabric_out  in  32  from interface.
- busy  out  1  reads in flight or FIFO non-empty.

Behaviour:
- Reset: one clock; reset is synchronous and active-low (clk, rst_n). While rst_n=0 at a clk edge:
  - inflight counter, valid shift register and FIFO pointers/count are cleared.
  - rsp_valid=0, busy=0.
  - wr_ready and rd_ready are held 0 during reset and for the first cycle after rst_n rises (registered init flag).
  - csb=web=reb=1.
- Reads in flight at reset are dropped; their returning data is never written to the FIFO.
- Issue logic is combinational from current state and inputs. The interface registers everything, so no extra stage is added here.
- wr_fire = wr_valid & wr_ready. wr_ready = 1 whenever the init flag is set.
- rd_fire = rd_valid & rd_ready. rd_ready = init & credit_ok & ~collide.
  - credit_ok: inflight + fifo_count < RSP_DEPTH.
  - collide: wr_valid & (rd_addr == wr_addr). The write wins; the read stalls one cycle and issues the next cycle at the earliest. A read issued one cycle after a write sees the new data.
- Interface drive:
  - web = ~wr_fire; reb = ~rd_fire; csb = ~(wr_fire | rd_fire).
  - addr_w = wr_addr, addr_r = rd_addr, d_fabric_in = wr_data; these are don't-care when not firing.
  - Simultaneous write and read to different addresses issue in the same cycle.
- Latency tracking:
  - LAT = BASE_LAT + cfg_out_reg (3 or 4).
  - A 4-bit shift register shifts rd_fire in each cycle. Bit LAT-1 high marks the return cycle, and d_fabric_out is pushed into the FIFO that cycle.
  - inflight (3 bits) increments on rd_fire and decrements on return; both in one cycle leave it unchanged.
- FIFO:
  - rsp_valid = ~empty; rsp_data = head entry (registered storage, no fall-through). Pop on rsp_valid & rsp_ready.
  - Push and pop in the same cycle are both performed and count is unchanged.
  - The credit rule makes overflow impossible; a push when full is a design error, flagged only by an assertion.
  - Pointers wrap modulo RSP_DEPTH.
- Response ordering equals issue order.
- busy = (inflight != 0) | ~empty.
- Changing cfg_out_reg or cfg_conf while busy: responses are undefined; no recovery is required.

Optional Feature:
- Macro SRAM_REQ_SEQ_PERF_EN.
- Defined:
  - Adds output rd_stall_cnt [15:0]: counts cycles with rd_valid & init & ~rd_ready, saturating at 16'hFFFF.
  - Adds input perf_clr: synchronous clear, priority over increment.
  - Cleared on reset.
- Undefined: neither port exists and there is no counter logic.

Test Plan:
- Reset hold: rst_n=0 for 3 cycles with wr_valid=rd_valid=1 -> csb=web=reb=1, ready=0, rsp_valid=0; wr_ready=1 on the second cycle after release.
- Write then read: write 0x3A5 data 0xDEADBEEF, next cycle read 0x3A5, out_reg=0 -> one FIFO push exactly 3 cycles after read issue, rsp_data=0xDEADBEEF.
- out_reg=1: same sequence -> push 4 cycles after issue; inflight reaches 1 and returns to 0.
- Collision: wr_valid and rd_valid both to 0x012 in the same cycle -> web=0, reb=1, rd_ready=0; read fires the next cycle.
- Credit/backpressure: rsp_ready=0, 6 back-to-back reads -> exactly 4 accepted, rd_ready=0 afterwards. Raise rsp_ready -> 4 responses in issue order, then the remaining reads issue.
- Reset mid-flight: 2 reads issued, rst_n=0 one cycle later -> FIFO stays empty, busy=0 after reset, no response appears.
